// File: rtl/pwm4_pkg.sv
// rtl/pwm4_pkg.sv - shared types and constants for the 4-bit PWM duty ramp
package pwm4_pkg;

    localparam int DUTY_W  = 4;
    localparam int PERIOD  = 16;
    localparam int PHASE_W = $clog2(PERIOD);

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_W-1:0] DUTY_MIN = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    // A divisor of zero would never produce a step, so it behaves as one.
    function automatic logic [DUTY_W-1:0] eff_div(input logic [DUTY_W-1:0] d);
        return (d == '0) ? DUTY_W'(1) : d;
    endfunction

endpackage

// File: rtl/pwm4_period_timer.sv
// rtl/pwm4_period_timer.sv - free-running PWM phase counter with end-of-period flag
module pwm4_period_timer
    import pwm4_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    output logic [PHASE_W-1:0] phase,
    output logic               period_end
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Phase is held at zero in reset, so this stays low there too.
    assign period_end = (phase == PHASE_W'(PERIOD - 1));

endmodule

// File: rtl/pwm4_duty_ramp.sv
// rtl/pwm4_duty_ramp.sv - ramps the PWM duty toward a requested target, one step per N periods
module pwm4_duty_ramp
    import pwm4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] tgt,
    input  logic [DUTY_W-1:0] tgt_div,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty,
    output logic              period_end,
    output logic              busy,
    output logic              done
);

    ramp_state_t       state;
    ramp_state_t       state_nxt;
    logic [DUTY_W-1:0] tgt_q;
    logic [DUTY_W-1:0] div_q;
    logic [DUTY_W-1:0] bcnt;
    logic              done_q;
    logic              done_nxt;
    logic              accept;
    logic              count_en;
    logic              step;
    logic              last_boundary;
    logic [DUTY_W-1:0] duty_stepped;
    logic [PHASE_W-1:0] pwm_phase_unused;

    pwm4_period_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .phase      (pwm_phase_unused),
        .period_end (period_end)
    );

    assign last_boundary = period_end && (bcnt == div_q - 1'b1);

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        count_en     = 1'b0;
        step         = 1'b0;
        done_nxt     = 1'b0;
        duty_stepped = duty;
        if (state == UP && duty != DUTY_MAX) begin
            duty_stepped = duty + 1'b1;
        end else if (state == DOWN && duty != DUTY_MIN) begin
            duty_stepped = duty - 1'b1;
        end
        case (state)
            IDLE: begin
                if (tgt_valid && !abort) begin
                    accept = 1'b1;
                    if (tgt > duty) begin
                        state_nxt = UP;
                    end else if (tgt < duty) begin
                        state_nxt = DOWN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            UP, DOWN: begin
                // Abort wins over a coincident step: duty freezes where it is.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (period_end) begin
                    count_en = 1'b1;
                    if (last_boundary) begin
                        step = 1'b1;
                        if (duty_stepped == tgt_q) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty   <= '0;
            tgt_q  <= '0;
            div_q  <= DUTY_W'(1);
            bcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (accept) begin
                tgt_q <= tgt;
                div_q <= eff_div(tgt_div);
                bcnt  <= '0;
            end else if (count_en) begin
                if (step) begin
                    duty <= duty_stepped;
                    bcnt <= '0;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    assign tgt_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: doc/pwm4_duty_ramp.md
PWM4_DUTY_RAMP -- requirements
Module: pwm4_duty_ramp

Interface
REQ-001 The module SHALL have exactly one clock and reset: clock `clk`, reset `rst`, asynchronous, active-high.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `tgt` in 4: requested target duty.
- `tgt_div` in 4: PWM periods per duty step.
- `tgt_valid` in 1: request valid.
- `tgt_ready` out 1: request accepted when high together with `tgt_valid`.
- `abort` in 1: synchronous ramp cancel.
- `duty` out 4: duty value driving the downstream 4-bit PWM duty input.
- `period_end` out 1: high on the last cycle (phase 15) of each 16-cycle PWM period.
- `busy` out 1: ramp in progress.
- `done` out 1: one-cycle ramp-complete pulse.

Function
REQ-003 Internal 4-bit phase counter SHALL increment every cycle and wrap 15->0.
- The counter is 0 in the first cycle after reset release, so it stays aligned with the downstream PWM counter released in the same cycle.
REQ-004 `period_end` SHALL equal (phase == 15).
REQ-005 `duty` SHALL change only on the clock edge that ends a `period_end` cycle (the period boundary), except on reset.
REQ-006 FSM states SHALL be IDLE, UP and DOWN; `tgt_ready` = (state == IDLE) and not `rst`; `busy` = (state != IDLE).
REQ-007 On acceptance (IDLE, `tgt_valid` high, `abort` low) the module SHALL latch `tgt` and `tgt_div`. An effective divisor of 0 SHALL be treated as 1. Next state:
- UP if `tgt` > `duty`.
- DOWN if `tgt` < `duty`.
- IDLE if `tgt` == `duty`, with `done` high in the next cycle.
REQ-008 In UP/DOWN, a period-boundary counter SHALL count boundaries.
- On the boundary where the count reaches divisor-1, `duty` SHALL step by +1 (UP) or -1 (DOWN) and the count SHALL clear.
- The count SHALL clear on acceptance, so the first step occurs on the divisor-th boundary after acceptance.
REQ-009 On the edge where the stepped `duty` equals the latched target, state SHALL return to IDLE. `done` SHALL be high for exactly the one cycle in which `duty` first shows the target value.
REQ-010 `duty` SHALL saturate in range 0..15. It SHALL never wrap 15->0 or 0->15.
REQ-011 Ramp duration SHALL be |target - start duty| x divisor x 16 cycles, give or take the phase at acceptance.
REQ-012 `abort` high in UP/DOWN SHALL return the FSM to IDLE on the next edge, with these effects:
- `duty` holds its current value.
- No `done` pulse is produced.
- `tgt_ready` is high the following cycle.
REQ-013 `abort` and `tgt_valid` high together in IDLE SHALL result in no acceptance, because `abort` has priority.
REQ-014 `tgt`/`tgt_div` changes while busy SHALL be ignored.

Reset
REQ-015 While `rst` is high, the following values SHALL apply immediately (asynchronously) and be held:
- `duty` = 0, phase = 0, state = IDLE, boundary count = 0.
- `done` = 0, `busy` = 0, `tgt_ready` = 0.
- `period_end` = 0.
REQ-016 Reset asserted mid-ramp SHALL abandon the ramp with no `done` pulse. The first cycle after release SHALL behave as post-power-up.

Structure
REQ-017 Shared package `pwm4_pkg` SHALL hold the state enum typedef and the constants DUTY_W = 4 and PERIOD = 16.
REQ-018 The phase counter and `period_end` generation SHALL be a sub-module `pwm4_period_timer`, reusable by the PWM stage. FSM and duty register SHALL live in `pwm4_duty_ramp`.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset release, `tgt`=5, `tgt_div`=1 accepted: `duty` steps 0->1->...->5, one step per boundary, 5 boundaries total. `done` is a single pulse in the cycle `duty`=5. `busy` is low afterwards.
- `duty`=12, `tgt`=3, `tgt_div`=2: 9 down-steps, each 32 cycles apart. `duty` is only ever observed changing on the edge after `period_end`.
- `tgt_div`=0, `tgt`=2 from 0: identical timing to `tgt_div`=1 (steps 16 cycles apart).
- `tgt`=`duty`=7: no `duty` change, `busy` never high, `done` high one cycle after acceptance, `tgt_ready` high throughout.
- Ramp 0->15 with `tgt_div`=1, `abort` at `duty`=9: `duty` holds 9, no `done`, `tgt_ready` high next cycle. Then `tgt`=15 completes at 15 with no wrap.
- `rst` pulsed mid-ramp at `duty`=6: `duty`=0 and `tgt_ready`=0 without waiting for a clock edge. After release, phase restarts at 0 and `period_end` first rises 15 cycles later.
